// File: rtl/ram_volts_tx.sv
// ram_volts_tx
// Walks sample RAM addresses 0..Depth-1 after a start pulse. Each sample is
// latched once and sent to the UART transmitter as two bytes: first the
// zero-padded upper bits (sample[Width-1:8]), then sample[7:0]. Every byte
// uses a txstart/txdone handshake.
//
// Ports:
//   clk_i      system clock, rising edge
//   rst_i      synchronous active-high reset
//   start_i    one-cycle frame request, only accepted in IDLE
//   addr_o     RAM read address (registered)
//   doutram_i  RAM read data, combinational from addr_o
//   txbyte_o   byte presented to the UART (registered)
//   txstart_o  one-cycle pulse telling the UART to latch txbyte_o
//   txdone_i   one-cycle pulse from the UART when the byte has been sent
//   busy_o     high from frame acceptance until done_o (registered)
//   done_o     one-cycle pulse after the last byte's txdone_i
module ram_volts_tx #(
  parameter int Width = 12,
  parameter int Depth = 310,
  parameter int AddrW = 9
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  output logic [AddrW-1:0] addr_o,
  input  logic [Width-1:0] doutram_i,
  output logic [7:0]       txbyte_o,
  output logic             txstart_o,
  input  logic             txdone_i,
  output logic             busy_o,
  output logic             done_o
);

  typedef enum logic [2:0] {
    IDLE, LOAD, SEND_HI, WAIT_HI, SEND_LO, WAIT_LO, NEXT, DONE
  } state_t;

  localparam logic [AddrW-1:0] LAST_ADDR = AddrW'(Depth - 1);

  state_t           state_reg, state_next;
  logic [Width-1:0] sample_reg, sample_next;
  logic [AddrW-1:0] addr_reg;
  logic [7:0]       txbyte_reg;
  logic             busy_reg;
  logic             last_addr;

  assign last_addr = (addr_reg == LAST_ADDR);

  // The sample is taken from the RAM only in LOAD. After that it is held,
  // so a RAM write during the byte transfers has no effect on this sample.
  always_comb begin
    sample_next = sample_reg;
    if (state_reg == LOAD) begin
      sample_next = doutram_i;
    end
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start_i) state_next = LOAD;
      LOAD:    state_next = SEND_HI;
      SEND_HI: state_next = WAIT_HI;
      WAIT_HI: if (txdone_i) state_next = SEND_LO;
      SEND_LO: state_next = WAIT_LO;
      WAIT_LO: if (txdone_i) state_next = NEXT;
      NEXT:    state_next = last_addr ? DONE : LOAD;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State decodes. Both come straight from the state register, so they do
  // not glitch at the clock edge.
  always_comb begin
    txstart_o = (state_reg == SEND_HI) || (state_reg == SEND_LO);
    done_o    = (state_reg == DONE);
  end

  // Datapath registers. The outgoing byte is loaded on the edge that enters
  // each SEND state, which makes it valid in the same cycle as txstart_o.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sample_reg <= '0;
      addr_reg   <= '0;
      txbyte_reg <= '0;
      busy_reg   <= 1'b0;
    end else begin
      sample_reg <= sample_next;
      busy_reg   <= (state_next != IDLE);
      case (state_reg)
        LOAD:    txbyte_reg <= 8'(sample_next >> 8);
        WAIT_HI: if (txdone_i) txbyte_reg <= sample_reg[7:0];
        NEXT:    if (!last_addr) addr_reg <= addr_reg + 1'b1;
        DONE:    addr_reg <= '0;
        default: ;
      endcase
    end
  end

  assign addr_o   = addr_reg;
  assign txbyte_o = txbyte_reg;
  assign busy_o   = busy_reg;

endmodule

// File: tb/tb_ram_volts_tx.sv
module tb_ram_volts_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start_w     [2];
  logic        extra_start [2];
  logic        start_in    [2];
  logic        txdone_w    [2];
  logic [7:0]  txbyte_w    [2];
  logic        txstart_w   [2];
  logic        busy_w      [2];
  logic        done_w      [2];
  logic [8:0]  addr_w      [2];
  logic [8:0]  addr0;
  logic [1:0]  addr1;
  logic [11:0] ram0 [0:511];
  logic [11:0] ram1 [0:3];
  logic [11:0] dout0, dout1;

  assign dout0 = ram0[addr0];
  assign dout1 = ram1[addr1];
  assign addr_w[0] = addr0;
  assign addr_w[1] = {7'd0, addr1};
  assign start_in[0] = start_w[0] | extra_start[0];
  assign start_in[1] = start_w[1] | extra_start[1];

  ram_volts_tx #(.Width(12), .Depth(310), .AddrW(9)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start_in[0]), .addr_o(addr0),
    .doutram_i(dout0), .txbyte_o(txbyte_w[0]), .txstart_o(txstart_w[0]),
    .txdone_i(txdone_w[0]), .busy_o(busy_w[0]), .done_o(done_w[0])
  );

  ram_volts_tx #(.Width(12), .Depth(3), .AddrW(2)) dut_small (
    .clk_i(clk), .rst_i(rst), .start_i(start_in[1]), .addr_o(addr1),
    .doutram_i(dout1), .txbyte_o(txbyte_w[1]), .txstart_o(txstart_w[1]),
    .txdone_i(txdone_w[1]), .busy_o(busy_w[1]), .done_o(done_w[1])
  );

  int checks = 0;
  int errors = 0;

  // UART model and observer state, one slot per DUT
  int         t_lat      [2] = '{10, 10};
  int         chaos      [2] = '{0, 0};
  int         cnt        [2] = '{0, 0};
  int         nbytes     [2] = '{0, 0};
  int         done_cnt   [2] = '{0, 0};
  int         period_err [2] = '{0, 0};
  int         addr_err   [2] = '{0, 0};
  int         last_hi    [2] = '{0, 0};
  int         cyc = 0;
  logic [7:0] got [2][1024];

  function automatic int depth_of(input int d);
    return (d == 0) ? 310 : 3;
  endfunction

  function automatic int sample_of(input int d, input int n);
    if (d == 0) return int'(ram0[n]);
    return int'(ram1[n]);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // UART model and byte observer. Runs 1 time unit after each rising edge.
  // txdone arrives T cycles after the txstart cycle. In chaos mode, extra
  // start pulses and spurious txdone pulses are injected.
  initial begin
    for (int d = 0; d < 2; d++) begin
      txdone_w[d] = 1'b0;
      extra_start[d] = 1'b0;
    end
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      for (int d = 0; d < 2; d++) begin
        extra_start[d] = 1'b0;
        txdone_w[d] = 1'b0;
        if (cnt[d] > 0) begin
          cnt[d]--;
          if (cnt[d] == 0) txdone_w[d] = 1'b1;
        end
        if (txstart_w[d]) begin
          if (nbytes[d] % 2 == 0) begin
            if (nbytes[d] > 0 && t_lat[d] == 1 && (cyc - last_hi[d]) != 6) period_err[d]++;
            if (int'(addr_w[d]) != nbytes[d] / 2) addr_err[d]++;
            last_hi[d] = cyc;
            if (chaos[d] != 0 && (nbytes[d] / 2) % 37 == 5) extra_start[d] = 1'b1;
          end else if (chaos[d] != 0) begin
            txdone_w[d] = 1'b1;
          end
          if (nbytes[d] < 1024) got[d][nbytes[d]] = txbyte_w[d];
          nbytes[d]++;
          cnt[d] = t_lat[d];
        end
        if (done_w[d]) done_cnt[d]++;
      end
    end
  end

  task automatic clear_obs(input int d);
    nbytes[d] = 0;
    done_cnt[d] = 0;
    period_err[d] = 0;
    addr_err[d] = 0;
  endtask

  task automatic start_pulse(input int d);
    @(negedge clk);
    start_w[d] = 1'b1;
    @(posedge clk);
    #2;
    chk("load_busy", 32'(busy_w[d]), 1);
    chk("load_no_txstart", 32'(txstart_w[d]), 0);
    @(negedge clk);
    start_w[d] = 1'b0;
    @(posedge clk);
    #2;
    chk("first_txstart", 32'(txstart_w[d]), 1);
    chk("first_hi_byte", 32'(txbyte_w[d]), 32'(sample_of(d, 0) / 256));
  endtask

  task automatic run_frame(input int d, input int t, input int ch);
    int budget, found, bad, depth;
    depth = depth_of(d);
    t_lat[d] = t;
    chaos[d] = ch;
    clear_obs(d);
    start_pulse(d);
    budget = depth * (2 * t + 4) + 50;
    found = 0;
    for (int i = 0; i < budget && found == 0; i++) begin
      tick();
      if (done_w[d]) found = 1;
    end
    chk("done_seen", 32'(found), 1);
    chk("bytes_at_done", 32'(nbytes[d]), 32'(2 * depth));
    chk("busy_at_done", 32'(busy_w[d]), 1);
    tick();
    chk("busy_after_done", 32'(busy_w[d]), 0);
    chk("done_one_cycle", 32'(done_w[d]), 0);
    bad = 0;
    for (int k = 0; k < 2 * depth; k++) begin
      int s, e;
      s = sample_of(d, k / 2);
      e = (k % 2 == 0) ? s / 256 : s % 256;
      if (int'(got[d][k]) != e) bad++;
    end
    chk("byte_sequence_bad_count", 32'(bad), 0);
    if (t == 1) chk("fast_period_errors", 32'(period_err[d]), 0);
    chk("addr_order_errors", 32'(addr_err[d]), 0);
    chk("done_count", 32'(done_cnt[d]), 1);
    chaos[d] = 0;
    $display("frame dut%0d T=%0d chaos=%0d bytes=%0d dones=%0d", d, t, ch, nbytes[d], done_cnt[d]);
  endtask

  initial begin
    int found, n0;
    rst = 1'b1;
    start_w[0] = 1'b0;
    start_w[1] = 1'b0;
    for (int n = 0; n < 512; n++) ram0[n] = 12'((n * 13) % 4096);
    ram1[0] = 12'hABC;
    ram1[1] = 12'hFFF;
    ram1[2] = 12'($urandom);
    ram1[3] = 12'h000;

    repeat (3) tick();
    for (int d = 0; d < 2; d++) begin
      chk("rst_addr", 32'(addr_w[d]), 0);
      chk("rst_busy", 32'(busy_w[d]), 0);
      chk("rst_txstart", 32'(txstart_w[d]), 0);
      chk("rst_done", 32'(done_w[d]), 0);
      chk("rst_txbyte", 32'(txbyte_w[d]), 0);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Full frame, RAM[n] = n*13 mod 4096, UART latency 10
    run_frame(0, 10, 0);

    // Random RAM contents, fast UART (6-cycle sample period)
    for (int n = 0; n < 512; n++) ram0[n] = 12'($urandom);
    run_frame(0, 1, 0);

    // Start pulses while busy and spurious txdone in SEND_LO
    run_frame(0, 10, 1);

    // Reset in the middle of a frame at sample 100
    t_lat[0] = 10;
    clear_obs(0);
    start_pulse(0);
    found = 0;
    for (int i = 0; i < 101 * 24 + 100 && found == 0; i++) begin
      tick();
      if (addr_w[0] == 9'd100) found = 1;
    end
    chk("reached_addr_100", 32'(found), 1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #2;
    chk("midrst_addr", 32'(addr_w[0]), 0);
    chk("midrst_busy", 32'(busy_w[0]), 0);
    chk("midrst_txstart", 32'(txstart_w[0]), 0);
    chk("midrst_done", 32'(done_w[0]), 0);
    chk("midrst_txbyte", 32'(txbyte_w[0]), 0);
    @(negedge clk);
    rst = 1'b0;
    n0 = nbytes[0];
    repeat (30) tick();
    chk("no_txstart_after_rst", 32'(nbytes[0]), 32'(n0));
    chk("idle_after_rst", 32'(busy_w[0]), 0);
    $display("reset mid-frame at addr 100, bytes before reset=%0d", n0);
    run_frame(0, 1, 0);

    // Small Depth=3 frame with byte packing checks, then immediate restart
    run_frame(1, 3, 0);
    chk("pack_0A", 32'(got[1][0]), 32'h0A);
    chk("pack_BC", 32'(got[1][1]), 32'hBC);
    chk("pack_0F", 32'(got[1][2]), 32'h0F);
    chk("pack_FF", 32'(got[1][3]), 32'hFF);
    run_frame(1, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_volts_tx.md
# ram_volts_tx

Downstream consumer of the 12-bit voltage sample RAM. On a start pulse it walks RAM addresses 0..Depth-1, reads each sample combinationally and hands it to the UART transmitter as two bytes (high nibble byte first, then low byte), using a start/done handshake per byte. Sits between the RAM and the UART TX module in the DAC/ADC capture-and-transmit path.

## Interface

Parameters:
- Width, 12, sample width in bits (fixed at 12 for byte packing; 9..16 permitted, high byte zero-padded)
- Depth, 310, number of samples per frame
- AddrW, 9, address width; must satisfy 2^AddrW >= Depth

Ports:
- clk_i  input  1  system clock, all logic on rising edge
- rst_i  input  1  synchronous, active-high reset
- start_i  input  1  one-cycle pulse requesting a frame transmission
- addr_o  output  AddrW  RAM read address
- doutram_i  input  Width  RAM read data (combinational from addr_o)
- txbyte_o  output  8  byte presented to UART TX
- txstart_o  output  1  one-cycle pulse: UART shall latch txbyte_o
- txdone_i  input  1  one-cycle pulse from UART: current byte fully sent
- busy_o  output  1  high from frame acceptance until done_o
- done_o  output  1  one-cycle pulse after last byte's txdone_i

## Operation

- States: IDLE, LOAD, SEND_HI, WAIT_HI, SEND_LO, WAIT_LO, NEXT, DONE.
- IDLE: addr_o=0, busy_o=0. start_i=1 -> LOAD.
- LOAD: sample register <= doutram_i (at current addr_o) -> SEND_HI.
- SEND_HI: txbyte_o = zero-extended sample[Width-1:8]; txstart_o=1 for this cycle only -> WAIT_HI.
- WAIT_HI: hold txbyte_o; on txdone_i=1 -> SEND_LO, else stay.
- SEND_LO: txbyte_o = sample[7:0]; txstart_o=1 this cycle -> WAIT_LO.
- WAIT_LO: on txdone_i=1 -> NEXT.
- NEXT: if addr_o == Depth-1 -> DONE; else addr_o <= addr_o+1 -> LOAD.
- DONE: done_o=1 one cycle, addr_o <= 0 -> IDLE.
- busy_o = 1 in every state except IDLE.
- start_i ignored in all states except IDLE (no queuing).
- txdone_i ignored outside WAIT_HI/WAIT_LO.
- Sample register isolates transmission from RAM writes during a byte; RAM is re-read only in LOAD.
- Address never exceeds Depth-1; no wrap-around within a frame.

## Timing

- Reset values: addr_o=0, txbyte_o=0, txstart_o=0, busy_o=0, done_o=0, state IDLE, sample register 0.
- Reset mid-frame: next cycle all outputs at reset values; no further txstart_o; a pending txdone_i is ignored.
- start_i sampled at edge k -> LOAD during cycle k+1 (busy_o=1), txstart_o high in cycle k+2.
- txdone_i sampled at edge j in WAIT_HI -> txstart_o for low byte high in cycle j+1.
- Per sample, with UART latency of T cycles from txstart_o to txdone_i: 2T + 4 cycles (LOAD, SEND_HI, SEND_LO, NEXT plus waits).
- done_o asserted the cycle after NEXT for address Depth-1; busy_o drops with done_o's falling cycle (IDLE).
- txdone_i coincident with txstart_o (same cycle) is not valid; earliest legal txdone_i is the cycle after txstart_o.
- start_i coincident with rst_i: reset wins.
- All outputs registered except txstart_o/done_o may be state decodes; must be glitch-free at clock edges.

## Test plan

- Full frame: RAM[n]=n*13 mod 4096, Depth=310, UART model T=10 -> 620 txstart_o pulses, bytes {RAM[n][11:8]},{RAM[n][7:0]} in address order, single done_o after last txdone_i.
- Byte packing: RAM[0]=12'hABC -> bytes 8'h0A then 8'hBC; RAM[1]=12'hFFF -> 8'h0F, 8'hFF.
- Fast UART: txdone_i one cycle after each txstart_o -> per-sample period exactly 6 cycles, addr_o increments by 1 every 6 cycles.
- Start while busy: extra start_i pulses mid-frame and a spurious txdone_i in SEND_LO -> byte sequence and count unchanged.
- Reset mid-frame: rst_i at sample 100 -> next cycle addr_o=0, busy_o=0, no txstart_o; subsequent start_i restarts from address 0.
- Small Depth=3: frame ends after address 2 (6 bytes), done_o one pulse, immediate new start_i in IDLE accepted.
